// File: rtl/audio_timer_pkg.sv
// Shared definitions for the interval-timer register map, control word encoding
// and the sequencer state machine.
package audio_timer_pkg;

    localparam logic [2:0] REG_STATUS   = 3'd0;
    localparam logic [2:0] REG_CONTROL  = 3'd1;
    localparam logic [2:0] REG_PERIOD_L = 3'd2;
    localparam logic [2:0] REG_PERIOD_H = 3'd3;
    localparam logic [2:0] REG_SNAP_L   = 3'd4;
    localparam logic [2:0] REG_SNAP_H   = 3'd5;

    localparam int BIT_ITO   = 0;
    localparam int BIT_CONT  = 1;
    localparam int BIT_START = 2;
    localparam int BIT_STOP  = 3;

    localparam logic [15:0] CTRL_START_CONT    = 16'((1 << BIT_ITO) | (1 << BIT_CONT) | (1 << BIT_START));
    localparam logic [15:0] CTRL_START_ONESHOT = 16'((1 << BIT_ITO) | (1 << BIT_START));
    localparam logic [15:0] CTRL_STOP          = 16'(1 << BIT_STOP);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_PL,
        ST_WR_PH,
        ST_WR_CTRL,
        ST_RUN,
        ST_WR_STOP,
        ST_WR_CLR,
        ST_CLR_WAIT,
        ST_WR_SNAP,
        ST_RD_L,
        ST_RD_L_WAIT,
        ST_RD_H,
        ST_RD_H_WAIT
    } state_t;

    function automatic logic [15:0] ctrl_start_word(input logic cont);
        return cont ? CTRL_START_CONT : CTRL_START_ONESHOT;
    endfunction

endpackage

// File: rtl/audio_timer_sequencer.sv
// Avalon-MM master that programs the interval timer, services its irq into
// frame ticks and reads back counter snapshots on request.
module audio_timer_sequencer
    import audio_timer_pkg::*;
#(
    parameter int TICK_CNT_W = 16,
    parameter bit CONTINUOUS = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           cfg_period,
    input  logic                  cfg_start,
    input  logic                  cfg_stop,
    input  logic                  snap_req,
    input  logic                  irq_in,
    output logic [2:0]            av_address,
    output logic                  av_chipselect,
    output logic                  av_write_n,
    output logic [15:0]           av_writedata,
    input  logic [15:0]           av_readdata,
    output logic                  tick,
    output logic [TICK_CNT_W-1:0] tick_count,
    output logic [31:0]           snap_value,
    output logic                  snap_valid,
    output logic                  busy,
    output logic                  err
);

    localparam logic [15:0] START_WORD = ctrl_start_word(CONTINUOUS);

    state_t r_state, w_state_nxt;

    logic [31:0] r_period, r_period_req, w_period_nxt;
    logic        r_pend_start, r_pend_stop, r_pend_snap;
    logic        w_start_ok, w_start_err;
    logic        w_req_start, w_req_stop, w_req_snap;
    logic        w_take_start, w_take_stop, w_take_snap;

    logic [2:0]  r_addr, w_addr;
    logic        r_cs, w_cs, r_wn, w_wn;
    logic [15:0] r_wdata, w_wdata;
    logic        r_tick, r_snap_valid, r_busy, r_err;
    logic [TICK_CNT_W-1:0] r_tick_cnt;
    logic [15:0] r_snap_lo;
    logic [31:0] r_snap_value;

    assign w_start_ok  = cfg_start && (cfg_period != 32'd0);
    assign w_start_err = cfg_start && (cfg_period == 32'd0);
    assign w_req_start = w_start_ok || r_pend_start;
    assign w_req_stop  = cfg_stop || r_pend_stop;
    assign w_req_snap  = snap_req || r_pend_snap;

    // A start taken this cycle uses the live cfg_period, otherwise the latest queued one.
    assign w_period_nxt = w_take_start ? (w_start_ok ? cfg_period : r_period_req) : r_period;

    always_comb begin
        w_state_nxt  = r_state;
        w_take_start = 1'b0;
        w_take_stop  = 1'b0;
        w_take_snap  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req_start) begin
                    w_state_nxt  = ST_WR_PL;
                    w_take_start = 1'b1;
                end
            end
            ST_WR_PL:   w_state_nxt = ST_WR_PH;
            ST_WR_PH:   w_state_nxt = ST_WR_CTRL;
            ST_WR_CTRL: w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (w_req_stop) begin
                    w_state_nxt = ST_WR_STOP;
                    w_take_stop = 1'b1;
                end else if (irq_in) begin
                    w_state_nxt = ST_WR_CLR;
                end else if (w_req_snap) begin
                    w_state_nxt = ST_WR_SNAP;
                    w_take_snap = 1'b1;
                end else if (w_req_start) begin
                    w_state_nxt  = ST_WR_PL;
                    w_take_start = 1'b1;
                end
            end
            ST_WR_STOP:   w_state_nxt = ST_IDLE;
            ST_WR_CLR:    w_state_nxt = ST_CLR_WAIT;
            ST_CLR_WAIT:  w_state_nxt = CONTINUOUS ? ST_RUN : ST_WR_CTRL;
            ST_WR_SNAP:   w_state_nxt = ST_RD_L;
            ST_RD_L:      w_state_nxt = ST_RD_L_WAIT;
            ST_RD_L_WAIT: w_state_nxt = ST_RD_H;
            ST_RD_H:      w_state_nxt = ST_RD_H_WAIT;
            ST_RD_H_WAIT: w_state_nxt = ST_RUN;
            default:      w_state_nxt = ST_IDLE;
        endcase
    end

    // Bus outputs are decoded from the next state so the registered strobe lines up with the state.
    always_comb begin
        w_cs    = 1'b0;
        w_wn    = 1'b1;
        w_addr  = REG_STATUS;
        w_wdata = 16'h0000;
        case (w_state_nxt)
            ST_WR_PL: begin
                w_cs = 1'b1; w_wn = 1'b0; w_addr = REG_PERIOD_L; w_wdata = w_period_nxt[15:0];
            end
            ST_WR_PH: begin
                w_cs = 1'b1; w_wn = 1'b0; w_addr = REG_PERIOD_H; w_wdata = w_period_nxt[31:16];
            end
            ST_WR_CTRL: begin
                w_cs = 1'b1; w_wn = 1'b0; w_addr = REG_CONTROL; w_wdata = START_WORD;
            end
            ST_WR_STOP: begin
                w_cs = 1'b1; w_wn = 1'b0; w_addr = REG_CONTROL; w_wdata = CTRL_STOP;
            end
            ST_WR_CLR: begin
                w_cs = 1'b1; w_wn = 1'b0; w_addr = REG_STATUS;
            end
            ST_WR_SNAP: begin
                w_cs = 1'b1; w_wn = 1'b0; w_addr = REG_SNAP_L;
            end
            ST_RD_L: begin
                w_cs = 1'b1; w_addr = REG_SNAP_L;
            end
            ST_RD_H: begin
                w_cs = 1'b1; w_addr = REG_SNAP_H;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_period     <= 32'd0;
            r_period_req <= 32'd0;
            r_pend_start <= 1'b0;
            r_pend_stop  <= 1'b0;
            r_pend_snap  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pend_start <= w_req_start && !w_take_start;
            if (r_state == ST_IDLE) begin
                r_pend_stop <= 1'b0;
                r_pend_snap <= 1'b0;
            end else begin
                r_pend_stop <= w_req_stop && !w_take_stop;
                r_pend_snap <= w_req_snap && !w_take_snap;
            end
            if (w_start_ok)
                r_period_req <= cfg_period;
            if (w_take_start)
                r_period <= w_period_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cs         <= 1'b0;
            r_wn         <= 1'b1;
            r_addr       <= 3'd0;
            r_wdata      <= 16'h0000;
            r_tick       <= 1'b0;
            r_tick_cnt   <= '0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
            r_snap_lo    <= 16'h0000;
            r_snap_value <= 32'd0;
            r_snap_valid <= 1'b0;
        end else begin
            r_cs    <= w_cs;
            r_wn    <= w_wn;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_tick  <= (w_state_nxt == ST_WR_CLR);
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_err   <= w_start_err;
            if (w_state_nxt == ST_WR_PL)
                r_tick_cnt <= '0;
            else if (w_state_nxt == ST_WR_CLR)
                r_tick_cnt <= r_tick_cnt + TICK_CNT_W'(1);
            if (r_state == ST_RD_L_WAIT)
                r_snap_lo <= av_readdata;
            if (r_state == ST_RD_H_WAIT)
                r_snap_value <= {av_readdata, r_snap_lo};
            r_snap_valid <= (r_state == ST_RD_H_WAIT);
        end
    end

    assign av_chipselect = r_cs;
    assign av_write_n    = r_wn;
    assign av_address    = r_addr;
    assign av_writedata  = r_wdata;
    assign tick          = r_tick;
    assign tick_count    = r_tick_cnt;
    assign snap_value    = r_snap_value;
    assign snap_valid    = r_snap_valid;
    assign busy          = r_busy;
    assign err           = r_err;

endmodule

// File: tb/tb_audio_timer_sequencer.sv
// Bench: two sequencers (continuous / one-shot with 4-bit tick counter) each
// paired with an interval-timer slave model, sharing the same config stimulus.
module tb_audio_timer_sequencer;
    import audio_timer_pkg::*;

    logic clk = 1'b0;
    logic reset, slv_rst;
    logic [31:0] cfg_period;
    logic cfg_start, cfg_stop, snap_req;
    logic [1:0] irq, cs, wn, tick, snap_vld, busy, err;
    logic [1:0][2:0] av_address;
    logic [1:0][15:0] wdata, rdata;
    logic [1:0][31:0] snapv;
    logic [15:0] tc0;
    logic [3:0] tc1;

    int n_chk = 0;
    int n_fail = 0;
    int n_os_ctrl = 0;

    always #5 clk = ~clk;

    audio_timer_sequencer #(.TICK_CNT_W(16), .CONTINUOUS(1'b1)) dut (
        .clk(clk), .reset(reset), .cfg_period(cfg_period), .cfg_start(cfg_start),
        .cfg_stop(cfg_stop), .snap_req(snap_req), .irq_in(irq[0]),
        .av_address(av_address[0]), .av_chipselect(cs[0]), .av_write_n(wn[0]),
        .av_writedata(wdata[0]), .av_readdata(rdata[0]), .tick(tick[0]),
        .tick_count(tc0), .snap_value(snapv[0]), .snap_valid(snap_vld[0]),
        .busy(busy[0]), .err(err[0]));

    audio_timer_sequencer #(.TICK_CNT_W(4), .CONTINUOUS(1'b0)) dut_os (
        .clk(clk), .reset(reset), .cfg_period(cfg_period), .cfg_start(cfg_start),
        .cfg_stop(cfg_stop), .snap_req(snap_req), .irq_in(irq[1]),
        .av_address(av_address[1]), .av_chipselect(cs[1]), .av_write_n(wn[1]),
        .av_writedata(wdata[1]), .av_readdata(rdata[1]), .tick(tick[1]),
        .tick_count(tc1), .snap_value(snapv[1]), .snap_valid(snap_vld[1]),
        .busy(busy[1]), .err(err[1]));

    // Interval-timer slave model: period write stops and reloads, START resumes.
    for (genvar g = 0; g < 2; g++) begin : g_slv
        logic [31:0] s_period, s_cnt, s_snap;
        logic s_run, s_ito, s_cont, s_to;
        logic [15:0] s_rd;
        always @(posedge clk or posedge slv_rst) begin
            if (slv_rst) begin
                s_period <= 0; s_cnt <= 0; s_snap <= 0; s_rd <= 0;
                s_run <= 0; s_ito <= 0; s_cont <= 0; s_to <= 0;
            end else begin
                if (s_run) begin
                    if (s_cnt == 0) begin
                        s_to <= 1'b1;
                        s_cnt <= s_period;
                        if (!s_cont) s_run <= 1'b0;
                    end else begin
                        s_cnt <= s_cnt - 1;
                    end
                end
                if (cs[g] && wn[g]) begin
                    case (av_address[g])
                        REG_STATUS: s_rd <= {15'd0, s_to};
                        REG_SNAP_L: s_rd <= s_snap[15:0];
                        REG_SNAP_H: s_rd <= s_snap[31:16];
                        default:    s_rd <= 16'h0000;
                    endcase
                end
                if (cs[g] && !wn[g]) begin
                    case (av_address[g])
                        REG_STATUS: s_to <= 1'b0;
                        REG_CONTROL: begin
                            s_ito  <= wdata[g][BIT_ITO];
                            s_cont <= wdata[g][BIT_CONT];
                            if (wdata[g][BIT_STOP]) s_run <= 1'b0;
                            else if (wdata[g][BIT_START]) s_run <= 1'b1;
                        end
                        REG_PERIOD_L: begin
                            s_period[15:0] <= wdata[g];
                            s_cnt <= {s_period[31:16], wdata[g]};
                            s_run <= 1'b0;
                            s_to  <= 1'b0;
                        end
                        REG_PERIOD_H: begin
                            s_period[31:16] <= wdata[g];
                            s_cnt <= {wdata[g], s_period[15:0]};
                            s_run <= 1'b0;
                        end
                        REG_SNAP_L: s_snap <= s_cnt;
                        default: ;
                    endcase
                end
            end
        end
        assign irq[g]   = s_to && s_ito;
        assign rdata[g] = s_rd;
    end

    always @(negedge clk)
        if (cs[1] && !wn[1] && av_address[1] == REG_CONTROL && wdata[1] == 16'h0005)
            n_os_ctrl++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_tick(input int idx, input int budget, output int waited);
        waited = -1;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (tick[idx]) begin
                waited = k;
                break;
            end
        end
    endtask

    typedef struct {
        logic        start;
        logic [31:0] period;
        logic        stop;
        logic        snap;
        logic        cs;
        logic        wn;
        logic [2:0]  addr;
        logic [15:0] wd;
        logic        bsy;
        logic        er;
        logic        sv;
    } vec_t;

    function automatic vec_t mk(input logic st, input logic [31:0] p, input logic sp, input logic sn,
                                input logic c, input logic w, input logic [2:0] a, input logic [15:0] d,
                                input logic b, input logic e, input logic v);
        vec_t r;
        r.start = st; r.period = p; r.stop = sp; r.snap = sn;
        r.cs = c; r.wn = w; r.addr = a; r.wd = d; r.bsy = b; r.er = e; r.sv = v;
        return r;
    endfunction

    vec_t tbl[19];

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int w;
        int base_ctrl;
        logic [15:0] base_tc;
        bit found;

        //            st  period         sp sn  cs wn addr wdata    bsy er sv
        tbl[0]  = mk(1, 32'd0,         0, 0,  0, 1, 0, 16'h0000, 0, 1, 0);
        tbl[1]  = mk(0, 32'd0,         0, 0,  0, 1, 0, 16'h0000, 0, 0, 0);
        tbl[2]  = mk(1, 32'd99,        0, 0,  1, 0, 2, 16'h0063, 1, 0, 0);
        tbl[3]  = mk(0, 32'd99,        0, 0,  1, 0, 3, 16'h0000, 1, 0, 0);
        tbl[4]  = mk(0, 32'd99,        0, 0,  1, 0, 1, 16'h0007, 1, 0, 0);
        tbl[5]  = mk(0, 32'd99,        0, 0,  0, 1, 0, 16'h0000, 1, 0, 0);
        tbl[6]  = mk(0, 32'd99,        1, 0,  1, 0, 1, 16'h0008, 1, 0, 0);
        tbl[7]  = mk(0, 32'd99,        0, 0,  0, 1, 0, 16'h0000, 0, 0, 0);
        tbl[8]  = mk(1, 32'h0001_86A0, 0, 0,  1, 0, 2, 16'h86A0, 1, 0, 0);
        tbl[9]  = mk(0, 32'h0001_86A0, 0, 0,  1, 0, 3, 16'h0001, 1, 0, 0);
        tbl[10] = mk(0, 32'h0001_86A0, 0, 0,  1, 0, 1, 16'h0007, 1, 0, 0);
        tbl[11] = mk(0, 32'h0001_86A0, 0, 0,  0, 1, 0, 16'h0000, 1, 0, 0);
        tbl[12] = mk(0, 32'h0001_86A0, 0, 1,  1, 0, 4, 16'h0000, 1, 0, 0);
        tbl[13] = mk(0, 32'h0001_86A0, 0, 0,  1, 1, 4, 16'h0000, 1, 0, 0);
        tbl[14] = mk(0, 32'h0001_86A0, 0, 0,  0, 1, 0, 16'h0000, 1, 0, 0);
        tbl[15] = mk(0, 32'h0001_86A0, 0, 0,  1, 1, 5, 16'h0000, 1, 0, 0);
        tbl[16] = mk(0, 32'h0001_86A0, 0, 0,  0, 1, 0, 16'h0000, 1, 0, 0);
        tbl[17] = mk(0, 32'h0001_86A0, 0, 0,  0, 1, 0, 16'h0000, 1, 0, 1);
        tbl[18] = mk(0, 32'h0001_86A0, 0, 0,  0, 1, 0, 16'h0000, 1, 0, 0);

        reset = 1'b1; slv_rst = 1'b1;
        cfg_period = 32'd0; cfg_start = 1'b0; cfg_stop = 1'b0; snap_req = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_bus", {cs[0], wn[0], av_address[0], wdata[0], tick[0], busy[0], err[0], snap_vld[0]},
              {1'b0, 1'b1, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0});
        check("reset_counts", {tc0, snapv[0]}, 48'd0);
        reset = 1'b0; slv_rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            cfg_start = tbl[i].start; cfg_period = tbl[i].period;
            cfg_stop = tbl[i].stop; snap_req = tbl[i].snap;
            @(negedge clk);
            cfg_start = 1'b0; cfg_stop = 1'b0; snap_req = 1'b0;
            check($sformatf("vec%0d", i),
                  {cs[0], wn[0], av_address[0], wdata[0], busy[0], err[0], snap_vld[0]},
                  {tbl[i].cs, tbl[i].wn, tbl[i].addr, tbl[i].wd, tbl[i].bsy, tbl[i].er, tbl[i].sv});
        end
        check("snap_hi", snapv[0][31:16], 16'h0001);
        check("snap_range", (snapv[0] <= 32'h0001_86A0 && snapv[0] >= 32'h0001_8690), 1);

        // Restart at period 99: first tick, then a tick every 100 cycles.
        base_ctrl = n_os_ctrl;
        cfg_period = 32'd99; cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        wait_tick(0, 300, w);
        check("first_tick_latency", (w + 1 >= 100 && w + 1 <= 110), 1);
        for (int i = 1; i < 10; i++) begin
            wait_tick(0, 150, w);
            check($sformatf("tick_interval%0d", i), w, 100);
        end
        check("tick_count10", tc0, 16'd10);

        // One-shot build: 4-bit tick counter wraps, START rewritten per tick.
        found = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (tc1 == 4'd15) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("os_reach15", found, 1);
        wait_tick(1, 300, w);
        check("os_wrap", {(w > 0), tc1}, {1'b1, 4'd0});
        repeat (4) @(negedge clk);
        check("os_ctrl_rewrites", n_os_ctrl - base_ctrl, 17);

        // Stop and irq in the same RUN cycle: stop wins, no status clear.
        found = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (irq[0]) begin
                found = 1'b1;
                break;
            end
        end
        check("irq_seen", found, 1);
        base_tc = tc0;
        cfg_stop = 1'b1;
        @(negedge clk);
        cfg_stop = 1'b0;
        check("stop_irq_write", {cs[0], wn[0], av_address[0], wdata[0], tick[0]},
              {1'b1, 1'b0, 3'd1, 16'h0008, 1'b0});
        @(negedge clk);
        check("stop_irq_idle", {busy[0], tick[0], cs[0], tc0}, {1'b0, 1'b0, 1'b0, base_tc});

        // Pending snap raised during WR_PL is taken at the first RUN decision.
        repeat (3) @(negedge clk);
        cfg_period = 32'd99; cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0; snap_req = 1'b1;
        @(negedge clk);
        snap_req = 1'b0;
        repeat (3) @(negedge clk);
        check("pend_snap", {cs[0], wn[0], av_address[0]}, {1'b1, 1'b0, 3'd4});

        // Two queued starts during the snapshot: the later period wins.
        cfg_period = 32'd50; cfg_start = 1'b1;
        @(negedge clk);
        cfg_period = 32'd60;
        @(negedge clk);
        cfg_start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (cs[0] && !wn[0] && av_address[0] == REG_PERIOD_L) begin
                found = 1'b1;
                break;
            end
        end
        check("pend_start_period", found ? wdata[0] : 16'hFFFF, 16'h003C);

        // Reset in RD_L_WAIT clears every output immediately; restart still works.
        repeat (3) @(negedge clk);
        snap_req = 1'b1;
        @(negedge clk);
        snap_req = 1'b0;
        repeat (2) @(negedge clk);
        check("rd_l_wait_state", {cs[0], busy[0]}, {1'b0, 1'b1});
        reset = 1'b1;
        #1;
        check("midreset_outputs", {cs[0], wn[0], av_address[0], wdata[0], tick[0], busy[0], err[0], snap_vld[0], tc0, snapv[0]},
              {1'b0, 1'b1, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 32'd0});
        @(negedge clk);
        reset = 1'b0;
        cfg_period = 32'd99; cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        check("restart_write", {cs[0], wn[0], av_address[0], wdata[0]}, {1'b1, 1'b0, 3'd2, 16'h0063});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
